// File: rtl/ctrl_defs.sv
// Shared definitions for the multi-cycle controller: state and opcode encodings,
// ALU function codes, select-line constants and the active-low register-select helper.
package ctrl_defs;

  localparam int IR_W = 16;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC1   = 3'd4,
    S_EXEC2   = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_LDI, CL_LDM, CL_STM, CL_ALU, CL_BRA, CL_BEQ, CL_BNE, CL_NOP, CL_HLT
  } iclass_t;

  localparam logic [3:0] OP_LDI = 4'h0, OP_LDM = 4'h1, OP_STM = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8, OP_LSL = 4'h9, OP_LSR = 4'hA, OP_BRA = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_NOP = 4'hE, OP_HLT = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000, ALU_NOT = 4'b0010, ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101, ALU_AND = 4'b0111, ALU_OR  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1010, ALU_LSL = 4'b1011, ALU_LSR = 4'b1100;

  localparam logic [1:0] RF_CLR  = 2'b00, RF_LOAD  = 2'b01;
  localparam logic [1:0] ARF_CLR = 2'b00, ARF_LOAD = 2'b01, ARF_INC = 2'b11;
  localparam logic [3:0] RF_SEL_NONE  = 4'b1111, RF_SEL_ALL  = 4'b0000;
  localparam logic [2:0] ARF_SEL_NONE = 3'b111,  ARF_SEL_ALL = 3'b000;
  localparam logic [2:0] ARF_SEL_PC   = 3'b110,  ARF_SEL_AR  = 3'b101;
  localparam logic [1:0] ARF_OUT_AR = 2'd0, ARF_OUT_PC = 2'd3;
  localparam logic [1:0] MUXA_ALU = 2'b00, MUXA_MEM = 2'b01, MUXA_IMM = 2'b10;
  localparam logic [1:0] MUXB_IMM = 2'b10, IR_LOAD = 2'b01;

  // Rn -> 4'b1110 rotated left by n: only the selected register's enable is low.
  function automatic logic [3:0] rf_sel_n(input logic [1:0] r);
    case (r)
      2'd0:    rf_sel_n = 4'b1110;
      2'd1:    rf_sel_n = 4'b1101;
      2'd2:    rf_sel_n = 4'b1011;
      default: rf_sel_n = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: instruction class, ALU function and whether execution needs a second cycle.
module ctrl_decode
  import ctrl_defs::*;
(
  input  logic [3:0] opcode_i,
  output logic [3:0] alu_fun_o,
  output iclass_t    iclass_o,
  output logic       two_cycle_o
);

  always_comb begin
    alu_fun_o = ALU_PASS;
    iclass_o  = CL_NOP;
    case (opcode_i)
      OP_LDI:  iclass_o = CL_LDI;
      OP_LDM:  iclass_o = CL_LDM;
      OP_STM:  iclass_o = CL_STM;
      OP_ADD:  begin iclass_o = CL_ALU; alu_fun_o = ALU_ADD; end
      OP_SUB:  begin iclass_o = CL_ALU; alu_fun_o = ALU_SUB; end
      OP_AND:  begin iclass_o = CL_ALU; alu_fun_o = ALU_AND; end
      OP_OR:   begin iclass_o = CL_ALU; alu_fun_o = ALU_OR;  end
      OP_XOR:  begin iclass_o = CL_ALU; alu_fun_o = ALU_XOR; end
      OP_NOT:  begin iclass_o = CL_ALU; alu_fun_o = ALU_NOT; end
      OP_LSL:  begin iclass_o = CL_ALU; alu_fun_o = ALU_LSL; end
      OP_LSR:  begin iclass_o = CL_ALU; alu_fun_o = ALU_LSR; end
      OP_BRA:  iclass_o = CL_BRA;
      OP_BEQ:  iclass_o = CL_BEQ;
      OP_BNE:  iclass_o = CL_BNE;
      OP_NOP:  iclass_o = CL_NOP;
      OP_HLT:  iclass_o = CL_HLT;
      default: iclass_o = CL_NOP;
    endcase
  end

  assign two_cycle_o = (iclass_o == CL_LDM) || (iclass_o == CL_STM);

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the 8-bit datapath: two-byte fetch, decode, one or two
// execute cycles. Outputs decode registered state plus IR; RST_N low forces the idle bundle.
module control_unit
  import ctrl_defs::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [IR_W-1:0] IR_Q,
  input  logic [3:0]      ALU_Flags,
  output logic [2:0]      RF_O1Sel,
  output logic [2:0]      RF_O2Sel,
  output logic [1:0]      RF_FunSel,
  output logic [3:0]      RF_RegSel,
  output logic [3:0]      RF_TSel,
  output logic [3:0]      ALU_FunSel,
  output logic [1:0]      ARF_OutASel,
  output logic [1:0]      ARF_OutBSel,
  output logic [1:0]      ARF_FunSel,
  output logic [2:0]      ARF_RegSel,
  output logic            IR_LH,
  output logic            IR_Enable,
  output logic [1:0]      IR_Funsel,
  output logic            Mem_WR,
  output logic            Mem_CS,
  output logic [1:0]      MuxSelA,
  output logic [1:0]      MuxSelB,
  output logic            MuxCSel,
  output logic            Halted,
  output logic [2:0]      State
);

  state_t     state_q, state_d;
  logic [3:0] alu_fun;
  iclass_t    iclass;
  logic       two_cycle;
  logic [1:0] rd, rs;
  logic       take_br;
  logic       unused_ok;

  assign rd = IR_Q[11:10];
  assign rs = IR_Q[9:8];
  // The immediate goes straight from IR to the datapath muxes; only Z steers control.
  assign unused_ok = &{1'b0, IR_Q[7:0], ALU_Flags[2:0]};

  ctrl_decode u_decode (
    .opcode_i    (IR_Q[15:12]),
    .alu_fun_o   (alu_fun),
    .iclass_o    (iclass),
    .two_cycle_o (two_cycle)
  );

  assign take_br = (iclass == CL_BRA) ||
                   ((iclass == CL_BEQ) &&  ALU_Flags[3]) ||
                   ((iclass == CL_BNE) && !ALU_Flags[3]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:    state_d = S_FETCH_L;
      S_FETCH_L: state_d = S_FETCH_H;
      S_FETCH_H: state_d = S_DECODE;
      S_DECODE:  state_d = S_EXEC1;
      S_EXEC1: begin
        if (two_cycle)             state_d = S_EXEC2;
        else if (iclass == CL_HLT) state_d = S_HALT;
        else                       state_d = S_FETCH_L;
      end
      S_EXEC2:   state_d = S_FETCH_L;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_comb begin
    RF_O1Sel    = '0;
    RF_O2Sel    = '0;
    RF_FunSel   = '0;
    RF_RegSel   = RF_SEL_NONE;
    RF_TSel     = RF_SEL_NONE;
    ALU_FunSel  = '0;
    ARF_OutASel = '0;
    ARF_OutBSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = ARF_SEL_NONE;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = '0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxSelA     = '0;
    MuxSelB     = '0;
    MuxCSel     = 1'b0;
    // Gating on RST_N stops any half-finished write the moment reset falls.
    if (RST_N) begin
      case (state_q)
        S_INIT: begin
          ARF_FunSel = ARF_CLR;
          ARF_RegSel = ARF_SEL_ALL;
          RF_FunSel  = RF_CLR;
          RF_RegSel  = RF_SEL_ALL;
          RF_TSel    = RF_SEL_ALL;
        end
        S_FETCH_L, S_FETCH_H: begin
          ARF_OutBSel = ARF_OUT_PC;
          Mem_CS      = 1'b0;
          IR_Enable   = 1'b1;
          IR_LH       = (state_q == S_FETCH_H);
          IR_Funsel   = IR_LOAD;
          ARF_RegSel  = ARF_SEL_PC;
          ARF_FunSel  = ARF_INC;
        end
        S_EXEC1: begin
          case (iclass)
            CL_LDI: begin
              MuxSelA   = MUXA_IMM;
              RF_FunSel = RF_LOAD;
              RF_RegSel = rf_sel_n(rd);
            end
            CL_LDM, CL_STM: begin
              MuxSelB    = MUXB_IMM;
              ARF_RegSel = ARF_SEL_AR;
              ARF_FunSel = ARF_LOAD;
            end
            CL_ALU: begin
              MuxCSel    = 1'b1;
              RF_O1Sel   = {1'b1, rd};
              RF_O2Sel   = {1'b1, rs};
              ALU_FunSel = alu_fun;
              MuxSelA    = MUXA_ALU;
              RF_FunSel  = RF_LOAD;
              RF_RegSel  = rf_sel_n(rd);
            end
            CL_BRA, CL_BEQ, CL_BNE: begin
              if (take_br) begin
                MuxSelB    = MUXB_IMM;
                ARF_RegSel = ARF_SEL_PC;
                ARF_FunSel = ARF_LOAD;
              end
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          if (iclass == CL_LDM) begin
            ARF_OutBSel = ARF_OUT_AR;
            Mem_CS      = 1'b0;
            MuxSelA     = MUXA_MEM;
            RF_FunSel   = RF_LOAD;
            RF_RegSel   = rf_sel_n(rd);
          end else if (iclass == CL_STM) begin
            ARF_OutBSel = ARF_OUT_AR;
            MuxCSel     = 1'b1;
            RF_O1Sel    = {1'b1, rd};
            ALU_FunSel  = ALU_PASS;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Halted = RST_N && (state_q == S_HALT);
  assign State  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of per-instruction control bundles driven with a forced IR,
// then program sequences run against a small behavioural datapath model.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] o1; logic [2:0] o2; logic [1:0] rf_fun; logic [3:0] rf_reg; logic [3:0] rf_t;
    logic [3:0] alu_fun; logic [1:0] outa; logic [1:0] outb; logic [1:0] arf_fun; logic [2:0] arf_reg;
    logic ir_lh; logic ir_en; logic [1:0] ir_fun; logic mem_wr; logic mem_cs;
    logic [1:0] mux_a; logic [1:0] mux_b; logic mux_c;
  } ctl_t;

  typedef struct {
    logic [15:0] ir; logic z; logic two; ctl_t e1; ctl_t e2;
  } vec_t;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic [15:0] IR_Q;
  logic [3:0] ALU_Flags;
  logic [2:0] RF_O1Sel, RF_O2Sel, ARF_RegSel, State;
  logic [1:0] RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, MuxSelA, MuxSelB;
  logic [3:0] RF_RegSel, RF_TSel, ALU_FunSel;
  logic IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

  control_unit dut (
    .CLK(CLK), .RST_N(RST_N), .IR_Q(IR_Q), .ALU_Flags(ALU_Flags),
    .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel),
    .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxSelA(MuxSelA), .MuxSelB(MuxSelB), .MuxCSel(MuxCSel),
    .Halted(Halted), .State(State)
  );

  always #5 CLK = ~CLK;

  // ---------------- datapath model ----------------
  logic use_model = 1'b0, load_img = 1'b0, z_drv = 1'b0;
  logic [15:0] ir_drv = 16'h0;
  logic [7:0] img [256];
  logic [7:0] mem [256];
  logic [7:0] rr [4];
  logic [7:0] pc = 8'h0, ar = 8'h0, sp = 8'h0;
  logic [15:0] ir_m = 16'h0;
  logic z_m = 1'b0;
  logic [7:0] o1, o2, alu_a, alu_out, addr_b, mem_out, muxa, muxb;
  ctl_t cur;

  assign IR_Q      = use_model ? ir_m : ir_drv;
  assign ALU_Flags = use_model ? {z_m, 3'b000} : {z_drv, 3'b000};
  assign cur = {RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RegSel, RF_TSel, ALU_FunSel, ARF_OutASel,
                ARF_OutBSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                Mem_CS, MuxSelA, MuxSelB, MuxCSel};

  always_comb begin
    o1 = RF_O1Sel[2] ? rr[RF_O1Sel[1:0]] : 8'h00;
    o2 = RF_O2Sel[2] ? rr[RF_O2Sel[1:0]] : 8'h00;
    alu_a = MuxCSel ? o1 : 8'h00;
    case (ALU_FunSel)
      4'b0010: alu_out = ~alu_a;
      4'b0100: alu_out = alu_a + o2;
      4'b0101: alu_out = alu_a - o2;
      4'b0111: alu_out = alu_a & o2;
      4'b1000: alu_out = alu_a | o2;
      4'b1010: alu_out = alu_a ^ o2;
      4'b1011: alu_out = alu_a << 1;
      4'b1100: alu_out = alu_a >> 1;
      default: alu_out = alu_a;
    endcase
    case (ARF_OutBSel)
      2'd0: addr_b = ar;
      2'd1: addr_b = sp;
      2'd3: addr_b = pc;
      default: addr_b = 8'h00;
    endcase
    mem_out = mem[addr_b];
    case (MuxSelA)
      2'b00: muxa = alu_out;
      2'b01: muxa = mem_out;
      2'b10: muxa = ir_m[7:0];
      default: muxa = 8'h00;
    endcase
    muxb = (MuxSelB == 2'b10) ? ir_m[7:0] : 8'h00;
  end

  function automatic logic [7:0] arf_nx(input logic [7:0] v, input logic [1:0] f, input logic [7:0] ld);
    case (f)
      2'b00: return 8'h00;
      2'b01: return ld;
      2'b11: return v + 8'h01;
      default: return v;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (!Mem_CS && Mem_WR) begin
      mem[addr_b] <= alu_out;
    end
    if (!ARF_RegSel[0]) pc <= arf_nx(pc, ARF_FunSel, muxb);
    if (!ARF_RegSel[1]) ar <= arf_nx(ar, ARF_FunSel, muxb);
    if (!ARF_RegSel[2]) sp <= arf_nx(sp, ARF_FunSel, muxb);
    for (int i = 0; i < 4; i++) begin
      if (!RF_RegSel[i]) rr[i] <= (RF_FunSel == 2'b00) ? 8'h00 : (RF_FunSel == 2'b01) ? muxa : rr[i];
    end
    if (RF_RegSel != 4'b1111 && RF_FunSel == 2'b01 && MuxSelA == 2'b00) z_m <= (alu_out == 8'h00);
    if (IR_Enable && IR_Funsel == 2'b01 && !Mem_CS) begin
      if (IR_LH) ir_m[15:8] <= mem_out;
      else       ir_m[7:0]  <= mem_out;
    end
  end

  // ---------------- expected-bundle constructors ----------------
  function automatic ctl_t c_idle();
    ctl_t c = '0;
    c.rf_reg = 4'hF; c.rf_t = 4'hF; c.arf_reg = 3'b111; c.mem_cs = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_init();
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_fetch(input logic lh);
    ctl_t c = c_idle();
    c.outb = 2'd3; c.mem_cs = 1'b0; c.ir_en = 1'b1; c.ir_lh = lh; c.ir_fun = 2'b01;
    c.arf_reg = 3'b110; c.arf_fun = 2'b11;
    return c;
  endfunction
  function automatic ctl_t c_rfload(input logic [3:0] rs_n, input logic [1:0] ma);
    ctl_t c = c_idle();
    c.rf_fun = 2'b01; c.rf_reg = rs_n; c.mux_a = ma;
    return c;
  endfunction
  function automatic ctl_t c_arload();
    ctl_t c = c_idle();
    c.mux_b = 2'b10; c.arf_reg = 3'b101; c.arf_fun = 2'b01;
    return c;
  endfunction
  function automatic ctl_t c_pcload();
    ctl_t c = c_idle();
    c.mux_b = 2'b10; c.arf_reg = 3'b110; c.arf_fun = 2'b01;
    return c;
  endfunction
  function automatic ctl_t c_alu(input logic [2:0] a, input logic [2:0] b, input logic [3:0] f,
                                 input logic [3:0] rs_n);
    ctl_t c = c_rfload(rs_n, 2'b00);
    c.mux_c = 1'b1; c.o1 = a; c.o2 = b; c.alu_fun = f;
    return c;
  endfunction
  function automatic ctl_t c_ldm2(input logic [3:0] rs_n);
    ctl_t c = c_rfload(rs_n, 2'b01);
    c.mem_cs = 1'b0;
    return c;
  endfunction
  function automatic ctl_t c_stm2(input logic [2:0] a);
    ctl_t c = c_idle();
    c.mux_c = 1'b1; c.o1 = a; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
    return c;
  endfunction

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic run_instr(output int cyc, output int wr, output int pcld);
    cyc = 0; wr = 0; pcld = 0;
    do begin
      if (!Mem_CS && Mem_WR) wr++;
      if (ARF_RegSel == 3'b110 && ARF_FunSel == 2'b01) pcld++;
      step();
      cyc++;
    end while (State != 3'd1 && cyc < 20);
  endtask

  vec_t vecs [18];
  int cyc, wr, pcld, n;
  logic ok;

  initial begin
    vecs[0]  = '{ir: 16'h085A, z: 1'b0, two: 1'b0, e1: c_rfload(4'b1011, 2'b10), e2: c_idle()};
    vecs[1]  = '{ir: 16'h0F12, z: 1'b0, two: 1'b0, e1: c_rfload(4'b0111, 2'b10), e2: c_idle()};
    vecs[2]  = '{ir: 16'h1433, z: 1'b0, two: 1'b1, e1: c_arload(), e2: c_ldm2(4'b1101)};
    vecs[3]  = '{ir: 16'h2C77, z: 1'b0, two: 1'b1, e1: c_arload(), e2: c_stm2(3'd7)};
    vecs[4]  = '{ir: 16'h3100, z: 1'b0, two: 1'b0, e1: c_alu(3'd4, 3'd5, 4'b0100, 4'b1110), e2: c_idle()};
    vecs[5]  = '{ir: 16'h4B00, z: 1'b0, two: 1'b0, e1: c_alu(3'd6, 3'd7, 4'b0101, 4'b1011), e2: c_idle()};
    vecs[6]  = '{ir: 16'h5500, z: 1'b0, two: 1'b0, e1: c_alu(3'd5, 3'd5, 4'b0111, 4'b1101), e2: c_idle()};
    vecs[7]  = '{ir: 16'h6E00, z: 1'b0, two: 1'b0, e1: c_alu(3'd7, 3'd6, 4'b1000, 4'b0111), e2: c_idle()};
    vecs[8]  = '{ir: 16'h7000, z: 1'b0, two: 1'b0, e1: c_alu(3'd4, 3'd4, 4'b1010, 4'b1110), e2: c_idle()};
    vecs[9]  = '{ir: 16'h8900, z: 1'b0, two: 1'b0, e1: c_alu(3'd6, 3'd5, 4'b0010, 4'b1011), e2: c_idle()};
    vecs[10] = '{ir: 16'h9C00, z: 1'b0, two: 1'b0, e1: c_alu(3'd7, 3'd4, 4'b1011, 4'b0111), e2: c_idle()};
    vecs[11] = '{ir: 16'hA300, z: 1'b0, two: 1'b0, e1: c_alu(3'd4, 3'd7, 4'b1100, 4'b1110), e2: c_idle()};
    vecs[12] = '{ir: 16'hB312, z: 1'b0, two: 1'b0, e1: c_pcload(), e2: c_idle()};
    vecs[13] = '{ir: 16'hC044, z: 1'b1, two: 1'b0, e1: c_pcload(), e2: c_idle()};
    vecs[14] = '{ir: 16'hC044, z: 1'b0, two: 1'b0, e1: c_idle(),   e2: c_idle()};
    vecs[15] = '{ir: 16'hD055, z: 1'b0, two: 1'b0, e1: c_pcload(), e2: c_idle()};
    vecs[16] = '{ir: 16'hD055, z: 1'b1, two: 1'b0, e1: c_idle(),   e2: c_idle()};
    vecs[17] = '{ir: 16'hE0FF, z: 1'b0, two: 1'b0, e1: c_idle(),   e2: c_idle()};

    // Reset state.
    #3;
    chk("rst_bundle", 64'(cur), 64'(c_idle()));
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_halted", 64'(Halted), 64'd0);
    step();
    RST_N = 1'b1;
    #1;
    chk("init_bundle", 64'(cur), 64'(c_init()));
    step();

    // Table-driven: one instruction per record, IR forced by the bench.
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d_state_fl", i), 64'(State), 64'd1);
      chk($sformatf("v%0d_fetch_l", i), 64'(cur), 64'(c_fetch(1'b0)));
      ir_drv = vecs[i].ir;
      z_drv  = vecs[i].z;
      step();
      chk($sformatf("v%0d_fetch_h", i), 64'(cur), 64'(c_fetch(1'b1)));
      step();
      chk($sformatf("v%0d_decode", i), 64'({State, cur}), 64'({3'd3, c_idle()}));
      step();
      chk($sformatf("v%0d_exec1", i), 64'({State, cur}), 64'({3'd4, vecs[i].e1}));
      if (vecs[i].two) begin
        step();
        chk($sformatf("v%0d_exec2", i), 64'({State, cur}), 64'({3'd5, vecs[i].e2}));
      end
      step();
    end

    // Reset asserted mid FETCH_H: idle at once; program image loaded while held.
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h00] = 8'h05; img[8'h01] = 8'h04;   // LDI R1,0x05
    img[8'h02] = 8'h03; img[8'h03] = 8'h08;   // LDI R2,0x03
    img[8'h04] = 8'h00; img[8'h05] = 8'h36;   // ADD R1,R2
    img[8'h06] = 8'h40; img[8'h07] = 8'h24;   // STM R1,0x40
    img[8'h08] = 8'h40; img[8'h09] = 8'h1C;   // LDM R3,0x40
    img[8'h0A] = 8'h00; img[8'h0B] = 8'h45;   // SUB R1,R1
    img[8'h0C] = 8'h20; img[8'h0D] = 8'hC0;   // BEQ 0x20
    img[8'h20] = 8'h30; img[8'h21] = 8'hD0;   // BNE 0x30
    img[8'h22] = 8'hAA; img[8'h23] = 8'h00;   // LDI R0,0xAA
    img[8'h24] = 8'hFE; img[8'h25] = 8'hB0;   // BRA 0xFE
    img[8'hFE] = 8'h00; img[8'hFF] = 8'hE0;   // NOP
    step();
    chk("pre_rst_fetch_h", 64'(State), 64'd2);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_bundle", 64'(cur), 64'(c_idle()));
    chk("rst_mid_state", 64'(State), 64'd0);
    use_model = 1'b1;
    load_img  = 1'b1;
    step();
    load_img  = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("rel_state_init", 64'(State), 64'd0);
    step();
    chk("rel_fetch_l_outb", 64'({State, ARF_OutBSel}), 64'({3'd1, 2'd3}));

    n = 0;
    for (int k = 0; k < 3; k++) begin
      run_instr(cyc, wr, pcld);
      chk($sformatf("prog_cyc%0d", k), 64'(cyc), 64'd4);
      n += cyc;
    end
    chk("add_total_cycles", 64'(n), 64'd12);
    chk("add_r1", 64'(rr[1]), 64'h08);
    chk("add_r2", 64'(rr[2]), 64'h03);

    run_instr(cyc, wr, pcld);
    chk("stm_cycles", 64'(cyc), 64'd5);
    chk("stm_write_cycles", 64'(wr), 64'd1);
    chk("stm_mem40", 64'(mem[8'h40]), 64'h08);
    run_instr(cyc, wr, pcld);
    chk("ldm_cycles", 64'(cyc), 64'd5);
    chk("ldm_no_write", 64'(wr), 64'd0);
    chk("ldm_r3", 64'(rr[3]), 64'h08);

    run_instr(cyc, wr, pcld);
    chk("sub_r1_zero", 64'({rr[1], z_m}), 64'({8'h00, 1'b1}));
    run_instr(cyc, wr, pcld);
    chk("beq_pc_load", 64'(pcld), 64'd1);
    chk("beq_pc", 64'(pc), 64'h20);
    run_instr(cyc, wr, pcld);
    chk("bne_no_load", 64'(pcld), 64'd0);
    chk("bne_pc", 64'(pc), 64'h22);
    run_instr(cyc, wr, pcld);
    chk("ldi_r0", 64'(rr[0]), 64'hAA);
    run_instr(cyc, wr, pcld);
    chk("bra_pc", 64'(pc), 64'hFE);
    run_instr(cyc, wr, pcld);
    chk("wrap_pc", 64'({State, pc}), 64'({3'd1, 8'h00}));
    run_instr(cyc, wr, pcld);
    chk("wrap_fetch_r1", 64'({rr[1], pc}), 64'({8'h05, 8'h02}));

    // HLT: absorbing until reset.
    RST_N = 1'b0;
    img[8'h01] = 8'hF0;
    load_img = 1'b1;
    step();
    load_img = 1'b0;
    RST_N = 1'b1;
    n = 0;
    while (!Halted && n < 10) begin
      step();
      n++;
    end
    chk("hlt_latency", 64'(n), 64'd5);
    chk("hlt_state", 64'(State), 64'd6);
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!(Halted && State == 3'd6 && Mem_CS && !Mem_WR && cur == c_idle())) ok = 1'b0;
    end
    chk("hlt_hold_100", 64'(ok), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("hlt_rst", 64'({Halted, State}), 64'({1'b0, 3'd0}));
    step();
    RST_N = 1'b1;
    #1;
    chk("hlt_rel_init", 64'(State), 64'd0);
    step();
    chk("hlt_rel_fetch", 64'(State), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
